// File: rtl/echo_pulse_meter.sv
// echo_pulse_meter: ultrasonic sensor driver that triggers, times the echo pulse and reports width/distance.
//   clk      in   system clock, all logic on posedge
//   reset_p  in   asynchronous active-high reset
//   start    in   single-cycle measurement request (ignored unless idle)
//   echo     in   asynchronous echo pulse from the sensor
//   trig     out  trigger pulse to the sensor (TRIG_US long)
//   busy     out  measurement in progress
//   done     out  one-cycle result-valid pulse
//   timeout  out  echo absent or longer than TIMEOUT_US
//   width_us out  echo high time in us
//   dist_cm  out  floor(width_us/58) when DIST_CM_EN is defined, else 0
// Optional feature macro: DIST_CM_EN
module echo_pulse_meter #(
  parameter int CLK_PER_US = 100,
  parameter int TRIG_US = 10,
  parameter int TIMEOUT_US = 30000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] width_us,
  output logic [15:0] dist_cm
);
  localparam int PW = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic us_tick, clr_pre, fin_fall, fin_to, fin_wto;
  logic [15:0] cnt, cnt_n, cnt_inc;
  // sync[1:0] is the two-flop synchronizer, sync[2] the previous synchronized value
  logic [2:0] sync;
  logic rise, fall;

  assign us_tick = pre == PW'(CLK_PER_US - 1);
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
  assign cnt_inc = &cnt ? cnt : cnt + 16'd1;
  assign trig = state == TRIG;
  assign busy = state == TRIG || state == WAIT_RISE || state == MEASURE;
  assign done = state == DONE;

  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      state <= IDLE;
      pre <= '0;
      cnt <= '0;
      sync <= '0;
    end else begin
      state <= state_n;
      pre <= clr_pre || us_tick ? '0 : pre + PW'(1);
      cnt <= cnt_n;
      sync <= {sync[1:0], echo};
    end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    clr_pre = 1'b0;
    fin_fall = 1'b0;
    fin_to = 1'b0;
    fin_wto = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          state_n = TRIG;
          cnt_n = '0;
          clr_pre = 1'b1;
        end
      TRIG:
        if (us_tick) begin
          cnt_n = cnt == 16'(TRIG_US - 1) ? '0 : cnt_inc;
          state_n = cnt == 16'(TRIG_US - 1) ? WAIT_RISE : TRIG;
        end
      WAIT_RISE:
        if (rise) begin
          state_n = MEASURE;
          cnt_n = '0;
        end else if (us_tick) begin
          cnt_n = cnt_inc;
          fin_wto = cnt_inc == 16'(TIMEOUT_US);
          state_n = fin_wto ? DONE : WAIT_RISE;
        end
      MEASURE: begin
        // cnt_n already includes a tick landing on the fall cycle, so a fall
        // coinciding with the last tick reports TIMEOUT_US without timeout
        cnt_n = us_tick ? cnt_inc : cnt;
        fin_fall = fall;
        fin_to = !fall && us_tick && cnt_inc == 16'(TIMEOUT_US);
        state_n = fin_fall || fin_to ? DONE : MEASURE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      timeout <= 1'b0;
      width_us <= '0;
    end else if (fin_fall || fin_to) begin
      timeout <= fin_to;
      width_us <= cnt_n;
    end else if (fin_wto) begin
      timeout <= 1'b1;
    end

`ifdef DIST_CM_EN
  logic [5:0] sub;
  logic [15:0] cm, cm_n;

  // one cm per 58 us of round-trip echo time
  assign cm_n = cm + {15'd0, state == MEASURE && us_tick && sub == 6'd57};

  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      sub <= '0;
      cm <= '0;
      dist_cm <= '0;
    end else begin
      sub <= state != MEASURE ? 6'd0 : !us_tick ? sub : sub == 6'd57 ? 6'd0 : sub + 6'd1;
      cm <= state != MEASURE ? 16'd0 : cm_n;
      if (fin_fall || fin_to)
        dist_cm <= cm_n;
    end
`else
  assign dist_cm = 16'd0;
`endif
endmodule

// File: tb/tb_echo_pulse_meter.sv
// tb_echo_pulse_meter: directed scoreboard bench for echo_pulse_meter with scaled-down timing.
module tb_echo_pulse_meter;
  localparam int CLK = 4;
  localparam int TRIG = 10;
  localparam int TMO = 1000;
`ifdef DIST_CM_EN
  localparam bit DIST = 1'b1;
`else
  localparam bit DIST = 1'b0;
`endif

  typedef struct {
    logic to;
    logic [15:0] w;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_p, start, echo;
  logic trig, busy, done, timeout;
  logic [15:0] width_us, dist_cm;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int tl, dc0;
  exp_t sb[$];

  echo_pulse_meter #(.CLK_PER_US(CLK), .TRIG_US(TRIG), .TIMEOUT_US(TMO)) dut (
    .clk(clk),
    .reset_p(reset_p),
    .start(start),
    .echo(echo),
    .trig(trig),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .width_us(width_us),
    .dist_cm(dist_cm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [15:0] dist_of(input int w);
    return DIST ? 16'(w / 58) : 16'd0;
  endfunction

  task automatic exp_push(input logic to, input int w);
    sb.push_back('{to, 16'(w), dist_of(w)});
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (trig && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag, input int budget, input int drop, input int exp_lat);
    exp_t e;
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i == drop - 1) echo = 1'b0;
      if (done) break;
    end
    chk({tag, "_seen"}, i < budget, 1);
    if (i < budget) begin
      chk({tag, "_sb"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_timeout"}, timeout, e.to);
        chk({tag, "_width"}, width_us, e.w);
        chk({tag, "_dist"}, dist_cm, e.d);
        if (exp_lat >= 0) chk({tag, "_lat"}, cyc - start_cyc, exp_lat);
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic edge_case(input string tag, input int k, input logic exp_to);
    exp_push(exp_to, TMO);
    pulse_start();
    while (cyc != start_cyc + 1 + k) @(negedge clk);
    echo = 1'b1;
    wait_done(tag, TMO * CLK + 100, TMO * CLK, -1);
    echo = 1'b0;
    hold(10);
  endtask

  initial begin
    reset_p = 1'b1;
    start = 1'b0;
    echo = 1'b0;
    hold(3);
    reset_p = 1'b0;
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_width", width_us, 0);
    chk("rst_dist", dist_cm, 0);

    // reset pulse while triggering
    pulse_start();
    hold(10);
    chk("t033_trig_on", trig, 1);
    chk("t033_busy_on", busy, 1);
    #2 reset_p = 1'b1;
    #1;
    chk("t033_trig_drop", trig, 0);
    chk("t033_busy_drop", busy, 0);
    @(negedge clk);
    reset_p = 1'b0;
    hold(100);
    chk("t033_no_done", done_cnt, 0);
    chk("t033_width", width_us, 0);
    chk("t033_timeout", timeout, 0);

    // normal 580 us echo
    exp_push(1'b0, 580);
    dc0 = done_cnt;
    pulse_start();
    wait_trig(tl);
    chk("t034_trig_len", tl, TRIG * CLK);
    hold(50);
    echo = 1'b1;
    hold(100);
    chk("t034_busy", busy, 1);
    hold(580 * CLK - 100);
    echo = 1'b0;
    wait_done("t034", 50, 0, -1);
    @(negedge clk);
    chk("t034_done_1cyc", done, 0);
    chk("t034_idle", busy, 0);
    hold(10);
    chk("t034_done_once", done_cnt, dc0 + 1);

    // echo never rises
    exp_push(1'b1, 580);
    pulse_start();
    wait_done("t035", TRIG * CLK + TMO * CLK + 100, 0, TRIG * CLK + TMO * CLK + 1);
    hold(5);

    // echo held high past the timeout
    exp_push(1'b1, TMO);
    dc0 = done_cnt;
    pulse_start();
    wait_trig(tl);
    hold(20);
    echo = 1'b1;
    wait_done("t036", TMO * CLK + 100, 0, -1);
    hold(400 * CLK);
    echo = 1'b0;
    hold(20);
    chk("t036_done_once", done_cnt, dc0 + 1);

    // second start during MEASURE is ignored
    exp_push(1'b0, 300);
    dc0 = done_cnt;
    pulse_start();
    wait_trig(tl);
    hold(30);
    echo = 1'b1;
    hold(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold(300 * CLK - 101);
    echo = 1'b0;
    wait_done("t037", 50, 0, -1);
    hold(100);
    chk("t037_done_once", done_cnt, dc0 + 1);
    chk("t037_idle", busy, 0);

    // echo already high at trigger end must fall and rise again
    exp_push(1'b0, 100);
    pulse_start();
    hold(5);
    echo = 1'b1;
    wait_trig(tl);
    hold(40);
    echo = 1'b0;
    hold(40);
    echo = 1'b1;
    hold(100 * CLK);
    echo = 1'b0;
    wait_done("t038", 50, 0, -1);
    // start during the DONE cycle is ignored
    start = 1'b1;
    @(negedge clk);
    chk("done_start_busy", busy, 0);
    start = 1'b0;
    hold(5);
    chk("done_start_trig", trig, 0);
    chk("done_start_busy2", busy, 0);

    // fall on the same tick that reaches the timeout, then one cycle later
    edge_case("fall_eq_to", 61, 1'b0);
    edge_case("fall_after_to", 62, 1'b1);

    // reset mid-measurement aborts without done
    dc0 = done_cnt;
    pulse_start();
    wait_trig(tl);
    hold(20);
    echo = 1'b1;
    hold(200);
    chk("abort_busy", busy, 1);
    #2 reset_p = 1'b1;
    #1;
    chk("abort_busy_drop", busy, 0);
    chk("abort_width", width_us, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_dist", dist_cm, 0);
    @(negedge clk);
    reset_p = 1'b0;
    echo = 1'b0;
    hold(50);
    chk("abort_no_done", done_cnt, dc0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
